// File: rtl/mul_booth_wallace_pipe.sv
// mul_booth_wallace_pipe: pipelined radix-4 Booth multiplier with a Wallace-tree reduction.
//   S1 forms the Booth partial products, S2 reduces them to sum/carry rows with 3:2 cells,
//   and S3 does the final add into out_prod. Handshakes are valid/ready at both ends, and a
//   tag rides alongside each operation. WIDTH must be even and at least 4.
//   Optional: define MUL_FLUSH_EN to add the flush input, which kills all in-flight operations.
module mul_booth_wallace_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag,
`ifdef MUL_FLUSH_EN
  input  logic               flush,
`endif
  output logic               busy
);

  localparam int EXT  = WIDTH + 2;      // extended operand width
  localparam int PW   = 2 * WIDTH;      // product width
  localparam int NDIG = WIDTH / 2 + 1;  // Booth digits over the extended multiplier
  localparam int ROWS = NDIG + 2;       // digit rows + correction-bit row + compensation row

  // Number of 3:2 levels needed to bring n rows down to two.
  function automatic int tree_levels(int n);
    int lv;
    int m;
    lv = 0;
    m  = n;
    while (m > 2) begin
      m  = 2 * (m / 3) + (m % 3);
      lv = lv + 1;
    end
    return lv;
  endfunction

  // Each row carries an inverted sign bit in place of its sign extension. This constant
  // subtracts the 2^(EXT+2i) that the inversion adds, so the rows sum to the true product.
  function automatic logic [PW-1:0] sign_comp();
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (EXT + 2 * i < PW) acc = acc + (PW'(1) << (EXT + 2 * i));
    end
    return ~acc + PW'(1);
  endfunction

  localparam int            LEVELS    = tree_levels(ROWS);
  localparam logic [PW-1:0] SIGN_COMP = sign_comp();

  // Pipeline state
  logic             v1_q, v2_q, v3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]    pp_q [ROWS];
  logic [PW-1:0]    sum_q, carry_q, prod_q;

  logic             adv1, adv2, adv3, flush_int;
  logic [EXT-1:0]   a_ext, b_ext;
  logic [EXT:0]     b_pad;
  logic [PW-1:0]    pp_d [ROWS];
  logic [PW-1:0]    sum_d, carry_d;

`ifdef MUL_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Handshake and stall chain; in_ready never looks at in_valid.
  assign adv3      = !v3_q || out_ready;
  assign adv2      = !v2_q || adv3;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1 && !flush_int;
  assign out_valid = v3_q;
  assign out_prod  = prod_q;
  assign out_tag   = tag3_q;
  assign busy      = v1_q || v2_q || v3_q;

  // Extension to EXT bits makes both modes a plain signed Booth multiply.
  assign a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
  assign b_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
  assign b_pad = {b_ext, 1'b0};

  // S1: Booth recoding and partial-product rows.
  always_comb begin
    logic [2:0]   trip;
    logic [EXT:0] mag;
    logic         neg;
    logic [EXT:0] row;
    pp_d[NDIG]     = '0;
    pp_d[NDIG + 1] = SIGN_COMP;
    for (int i = 0; i < NDIG; i++) begin
      trip = b_pad[2 * i +: 3];
      mag  = '0;
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: mag = {a_ext[EXT-1], a_ext};
        3'b011:         mag = {a_ext, 1'b0};
        3'b100: begin
          mag = {a_ext, 1'b0};
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = {a_ext[EXT-1], a_ext};
          neg = 1'b1;
        end
        default: begin
          mag = '0;
          neg = 1'b0;
        end
      endcase
      // One's complement here; the +1 lands in the correction row at the digit's weight.
      row               = neg ? ~mag : mag;
      pp_d[i]           = PW'({~row[EXT], row[EXT-1:0]}) << (2 * i);
      pp_d[NDIG][2 * i] = neg;
    end
  end

  // S1 register: partial-product rows, tag and valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1_q   <= 1'b0;
      tag1_q <= '0;
      for (int r = 0; r < ROWS; r++) pp_q[r] <= '0;
    end else begin
      if (flush_int) begin
        v1_q <= 1'b0;
      end else if (adv1) begin
        v1_q <= in_valid;
      end
      if (in_valid && in_ready) begin
        tag1_q <= in_tag;
        for (int r = 0; r < ROWS; r++) pp_q[r] <= pp_d[r];
      end
    end
  end

  // S2: Wallace tree of per-column 3:2 cells down to sum and carry rows.
  always_comb begin
    logic [PW-1:0] w [ROWS];
    logic [PW-1:0] n [ROWS];
    int            cnt;
    int            grp;
    for (int r = 0; r < ROWS; r++) begin
      w[r] = pp_q[r];
      n[r] = '0;
    end
    cnt = ROWS;
    for (int lv = 0; lv < LEVELS; lv++) begin
      grp = cnt / 3;
      for (int r = 0; r < ROWS; r++) n[r] = '0;
      for (int k = 0; k < ROWS / 3; k++) begin
        if (k < grp) begin
          n[2 * k]     = w[3 * k] ^ w[3 * k + 1] ^ w[3 * k + 2];
          // Shift drops the carry out of the top column.
          n[2 * k + 1] = ((w[3 * k] & w[3 * k + 1]) | (w[3 * k] & w[3 * k + 2]) |
                          (w[3 * k + 1] & w[3 * k + 2])) << 1;
        end
      end
      // Leftover rows (fewer than three) pass straight through to the next level.
      for (int j = 0; j < 2; j++) begin
        if (j < cnt - 3 * grp) n[2 * grp + j] = w[3 * grp + j];
      end
      cnt = cnt - grp;
      for (int r = 0; r < ROWS; r++) w[r] = n[r];
    end
    sum_d   = w[0];
    carry_d = w[1];
  end

  // S2 register: sum and carry rows.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v2_q    <= 1'b0;
      tag2_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      if (flush_int) begin
        v2_q <= 1'b0;
      end else if (adv2) begin
        v2_q <= v1_q;
      end
      if (adv2 && v1_q) begin
        tag2_q  <= tag1_q;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  // S3 register: final carry-propagate add into the output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v3_q   <= 1'b0;
      tag3_q <= '0;
      prod_q <= '0;
    end else begin
      if (flush_int) begin
        v3_q <= 1'b0;
      end else if (adv3) begin
        v3_q <= v2_q;
      end
      if (adv3 && v2_q) begin
        tag3_q <= tag2_q;
        prod_q <= sum_q + carry_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_booth_wallace_pipe.sv
// Testbench for mul_booth_wallace_pipe (WIDTH=32, TAG_W=5). The reference model is plain
// 64-bit multiplication of the extended operands; flush scenario only with MUL_FLUSH_EN.
module tb_mul_booth_wallace_pipe;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int P  = 2 * W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [P-1:0]  out_prod;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef MUL_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_booth_wallace_pipe #(
    .WIDTH (W),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag),
`ifdef MUL_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy)
  );

  function automatic logic [P-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [P-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (out_prod !== '0) begin n_fail++; $display("FAIL reset_out_prod got %h want 0", out_prod); end
    n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    resetn = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed(input string name, input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [TW-1:0] tag,
                               input logic [P-1:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; in_signed = s; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept in_ready %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early1 out_valid %b want 0", name, out_valid); end
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early2 out_valid %b want 0", name, out_valid); end
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency out_valid %b want 1", name, out_valid); end
    n_tests++; if (out_prod !== exp) begin n_fail++; $display("FAIL %s_prod got %h want %h", name, out_prod, exp); end
    n_tests++; if (out_tag !== tag) begin n_fail++; $display("FAIL %s_tag got %h want %h", name, out_tag, tag); end
  endtask

  task automatic test_back_to_back();
    logic [P-1:0]  q_prod [$];
    logic [TW-1:0] q_tag [$];
    int            q_cyc [$];
    int            sent, got, c0;
    logic [P-1:0]  ep;
    logic [TW-1:0] et;
    sent = 0; got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (sent < 10) begin
        in_valid = 1'b1; in_signed = 1'($urandom_range(0, 1));
        in_a = $urandom; in_b = $urandom; in_tag = sent[TW-1:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        got++;
        n_tests++;
        if (q_prod.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious out_valid=1 with nothing outstanding, tag %h", out_tag);
        end else begin
          ep = q_prod.pop_front(); et = q_tag.pop_front(); c0 = q_cyc.pop_front();
          if (out_prod !== ep) begin n_fail++; $display("FAIL b2b_prod got %h want %h", out_prod, ep); end
          n_tests++; if (out_tag !== et) begin n_fail++; $display("FAIL b2b_tag got %h want %h", out_tag, et); end
          n_tests++; if (cyc !== c0 + 3) begin n_fail++; $display("FAIL b2b_cycle got %0d want %0d", cyc, c0 + 3); end
        end
      end
      if (in_valid) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready);
        end else begin
          q_prod.push_back(ref_mul(in_signed, in_a, in_b)); q_tag.push_back(in_tag);
          q_cyc.push_back(cyc); sent++;
        end
      end
    end
    in_valid = 1'b0;
    n_tests++; if (got !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", got); end
  endtask

  task automatic test_backpressure();
    logic [P-1:0]  q_prod [$];
    logic [TW-1:0] q_tag [$];
    logic [W-1:0]  ops_a [5];
    logic [W-1:0]  ops_b [5];
    logic          ops_s [5];
    logic [P-1:0]  hold_p, ep;
    logic [TW-1:0] hold_t, et;
    logic          hold_v;
    int            sent, got;
    sent = 0; got = 0; hold_v = 1'b0; hold_p = '0; hold_t = '0;
    for (int i = 0; i < 5; i++) begin
      ops_a[i] = $urandom; ops_b[i] = $urandom; ops_s[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6);
      in_valid  = (sent < 5);
      if (sent < 5) begin
        in_a = ops_a[sent]; in_b = ops_b[sent]; in_signed = ops_s[sent];
        in_tag = TW'(sent + 16);
      end
      #1;
      if (cyc >= 3 && cyc < 6) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready cyc %0d got %b want 0", cyc, in_ready); end
      end
      if (cyc == 6) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
      end
      if (cyc >= 6 && cyc <= 10) begin
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_bubble cyc %0d out_valid %b want 1", cyc, out_valid); end
      end
      if (out_valid && !out_ready) begin
        if (hold_v) begin
          n_tests++; if (out_prod !== hold_p) begin n_fail++; $display("FAIL bp_stable_prod got %h want %h", out_prod, hold_p); end
          n_tests++; if (out_tag !== hold_t) begin n_fail++; $display("FAIL bp_stable_tag got %h want %h", out_tag, hold_t); end
        end
        hold_p = out_prod; hold_t = out_tag; hold_v = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q_prod.size() == 0) begin
          n_fail++; $display("FAIL bp_duplicate out_valid=1 with nothing outstanding, tag %h", out_tag);
        end else begin
          ep = q_prod.pop_front(); et = q_tag.pop_front(); got++;
          if (out_prod !== ep) begin n_fail++; $display("FAIL bp_prod got %h want %h", out_prod, ep); end
          n_tests++; if (out_tag !== et) begin n_fail++; $display("FAIL bp_tag got %h want %h", out_tag, et); end
        end
      end
      if (in_valid && in_ready) begin
        q_prod.push_back(ref_mul(in_signed, in_a, in_b)); q_tag.push_back(in_tag); sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++; if (got !== 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got); end
  endtask

  task automatic test_random_stall();
    logic [P-1:0]  q_prod [$];
    logic [TW-1:0] q_tag [$];
    logic [P-1:0]  ep, prev_p;
    logic [TW-1:0] et, prev_t;
    logic          prev_stall;
    prev_stall = 1'b0; prev_p = '0; prev_t = '0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 300) begin
        in_valid = ($urandom_range(0, 9) < 7); out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom_range(0, 1));
      in_tag = TW'($urandom);
      #1;
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_prod !== prev_p || out_tag !== prev_t) begin
          n_fail++;
          $display("FAIL rnd_hold got v=%b %h/%h want v=1 %h/%h", out_valid, out_prod, out_tag, prev_p, prev_t);
        end
      end
      prev_stall = out_valid && !out_ready; prev_p = out_prod; prev_t = out_tag;
      if (out_valid && out_ready) begin
        n_tests++;
        if (q_prod.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious out_valid=1 with nothing outstanding");
        end else begin
          ep = q_prod.pop_front(); et = q_tag.pop_front();
          if (out_prod !== ep || out_tag !== et) begin
            n_fail++; $display("FAIL rnd_result got %h/%h want %h/%h", out_prod, out_tag, ep, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        q_prod.push_back(ref_mul(in_signed, in_a, in_b)); q_tag.push_back(in_tag);
      end
    end
    n_tests++; if (q_prod.size() != 0) begin n_fail++; $display("FAIL rnd_drain left %0d want 0", q_prod.size()); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_signed = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'h0A;
    @(posedge clk); #1;
    in_a = $urandom; in_tag = 5'h0B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
    #1; resetn = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(posedge clk); #2;
    resetn = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost cyc %0d out_valid %b want 0", c, out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready cyc %0d got %b want 1", c, in_ready); end
    end
  endtask

`ifdef MUL_FLUSH_EN
  task automatic test_flush();
    logic [P-1:0] ep;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_signed = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = TW'(i + 1);
    end
    @(posedge clk); #1;
    flush = 1'b1; in_a = $urandom; in_tag = 5'h1F;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_signed = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'h15;
    ep = ref_mul(in_signed, in_a, in_b);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_new_accept got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_killed1 out_valid %b want 0", out_valid); end
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_killed2 out_valid %b want 0", out_valid); end
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_new_valid got %b want 1", out_valid); end
    n_tests++; if (out_prod !== ep) begin n_fail++; $display("FAIL flush_new_prod got %h want %h", out_prod, ep); end
    n_tests++; if (out_tag !== 5'h15) begin n_fail++; $display("FAIL flush_new_tag got %h want 15", out_tag); end
    @(posedge clk); #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after out_valid %b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed("u_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 64'hFFFFFFFE00000001);
    test_directed("s_m1m1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 64'h0000000000000001);
    test_directed("s_minmin", 1'b1, 32'h80000000, 32'h80000000, 5'h05, 64'h4000000000000000);
    test_directed("s_min1", 1'b1, 32'h80000000, 32'h00000001, 5'h06, 64'hFFFFFFFF80000000);
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midflight();
`ifdef MUL_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a scenario wedges the simulation.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
